// File: rtl/noc_vc_credit_arbiter.sv
// Credit-based round-robin wormhole arbiter for one NoC output link.
// Define NOC_VC_ARB_STATS_EN to add per-VC flit counters and a lock-stall counter.
module noc_vc_credit_arbiter #(
   parameter int VC_W       = 2,
   parameter int PACKET_W   = 32,
   parameter int LAST_BIT   = 16,
   parameter int FIFO_DEPTH = 32,
   parameter int CNT_W      = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [VC_W-1:0]       in_valid,
   input  logic [VC_W*PACKET_W-1:0] in_packet,
   output logic [VC_W-1:0]       in_ready,
   input  logic [VC_W-1:0]       credit_return,
   output logic                  out_valid,
   output logic [VC_W-1:0]       out_vc,
   output logic [PACKET_W-1:0]   out_packet,
   output logic [VC_W*CNT_W-1:0] credits,
   output logic                  credit_err
`ifdef NOC_VC_ARB_STATS_EN
   ,
   output logic [VC_W*32-1:0]    flit_cnt,
   output logic [31:0]           lock_stall_cnt
`endif
);

   localparam int IDX_W = (VC_W > 1) ? $clog2(VC_W) : 1;
   localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(FIFO_DEPTH - 1);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e            state_q;
   logic [IDX_W-1:0]  lock_q;
   logic [IDX_W-1:0]  rr_q;
   logic [IDX_W-1:0]  rr_d;
   logic [CNT_W-1:0]  cred_q [VC_W];
   logic [CNT_W-1:0]  cred_d [VC_W];
   logic [VC_W-1:0]   ovf_d;
   logic              err_q;
   logic              out_valid_q;
   logic [VC_W-1:0]   out_vc_q;
   logic [PACKET_W-1:0] out_packet_q;

   logic [VC_W-1:0]   elig;
   logic [VC_W-1:0]   send;
   logic              gnt_vld;
   logic [IDX_W-1:0]  gnt_idx;
   logic [PACKET_W-1:0] gnt_pkt;
   logic              gnt_last;

   // In LOCKED only the owner may go; otherwise search upward from rr_q.
   always_comb begin
      int j;
      j       = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int v = 0; v < VC_W; v++) begin
         elig[v] = in_valid[v] && (cred_q[v] != '0);
      end
      if (!rst) begin
         if (state_q == LOCKED) begin
            gnt_vld = elig[lock_q];
            gnt_idx = lock_q;
         end else begin
            for (int i = 0; i < VC_W; i++) begin
               j = int'(rr_q) + i;
               if (j >= VC_W) j = j - VC_W;
               if (!gnt_vld && elig[j]) begin
                  gnt_vld = 1'b1;
                  gnt_idx = IDX_W'(j);
               end
            end
         end
      end
   end

   assign in_ready = gnt_vld ? (VC_W'(1) << gnt_idx) : '0;
   assign send     = in_ready;
   assign gnt_pkt  = in_packet[gnt_idx*PACKET_W +: PACKET_W];
   assign gnt_last = gnt_pkt[LAST_BIT];
   assign rr_d     = (int'(gnt_idx) == VC_W - 1) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      for (int v = 0; v < VC_W; v++) begin
         cred_d[v] = cred_q[v];
         ovf_d[v]  = 1'b0;
         if (send[v] && !credit_return[v]) begin
            cred_d[v] = cred_q[v] - 1'b1;
         end else if (!send[v] && credit_return[v]) begin
            if (cred_q[v] == CRED_MAX) ovf_d[v] = 1'b1;
            else cred_d[v] = cred_q[v] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         lock_q       <= '0;
         rr_q         <= '0;
         err_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         out_vc_q     <= '0;
         out_packet_q <= '0;
         for (int v = 0; v < VC_W; v++) cred_q[v] <= CRED_MAX;
      end else begin
         for (int v = 0; v < VC_W; v++) cred_q[v] <= cred_d[v];
         if (|ovf_d) err_q <= 1'b1;
         out_valid_q <= gnt_vld;
         if (gnt_vld) begin
            out_vc_q     <= in_ready;
            out_packet_q <= gnt_pkt;
            rr_q         <= rr_d;
            unique case (state_q)
               IDLE: begin
                  if (!gnt_last) begin
                     state_q <= LOCKED;
                     lock_q  <= gnt_idx;
                  end
               end
               LOCKED: begin
                  if (gnt_last) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_vc     = out_vc_q;
   assign out_packet = out_packet_q;
   assign credit_err = err_q;

   always_comb begin
      credits = '0;
      for (int v = 0; v < VC_W; v++) credits[v*CNT_W +: CNT_W] = cred_q[v];
   end

`ifdef NOC_VC_ARB_STATS_EN
   logic [31:0] flit_cnt_q [VC_W];
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         for (int v = 0; v < VC_W; v++) flit_cnt_q[v] <= '0;
      end else begin
         for (int v = 0; v < VC_W; v++) begin
            if (send[v]) flit_cnt_q[v] <= flit_cnt_q[v] + 32'd1;
         end
         if (state_q == LOCKED && !gnt_vld && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   always_comb begin
      flit_cnt = '0;
      for (int v = 0; v < VC_W; v++) flit_cnt[v*32 +: 32] = flit_cnt_q[v];
   end

   assign lock_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_noc_vc_credit_arbiter.sv
// Directed self-checking bench for noc_vc_credit_arbiter (default parameters).
// Stats ports are checked only when NOC_VC_ARB_STATS_EN is defined.
module tb_noc_vc_credit_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  in_valid;
   logic [63:0] in_packet;
   logic [1:0]  in_ready;
   logic [1:0]  credit_return;
   logic        out_valid;
   logic [1:0]  out_vc;
   logic [31:0] out_packet;
   logic [9:0]  credits;
   logic        credit_err;
`ifdef NOC_VC_ARB_STATS_EN
   logic [63:0] flit_cnt;
   logic [31:0] lock_stall_cnt;
`endif

   int n_chk = 0;
   int n_fail = 0;

   noc_vc_credit_arbiter dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_packet(in_packet),
      .in_ready(in_ready),
      .credit_return(credit_return),
      .out_valid(out_valid),
      .out_vc(out_vc),
      .out_packet(out_packet),
      .credits(credits),
      .credit_err(credit_err)
`ifdef NOC_VC_ARB_STATS_EN
      ,
      .flit_cnt(flit_cnt),
      .lock_stall_cnt(lock_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [15:0] d, input logic last);
      return {15'd0, last, d};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      in_valid = '0;
      credit_return = '0;
      in_packet = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 2'b11;
      credit_return = '0;
      in_packet = {mk(16'h1, 1'b1), mk(16'h2, 1'b1)};
      tick();
      tick();
      n_chk++;
      if (out_valid !== 1'b0 || out_vc !== 2'b00 || out_packet !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_out: valid=%b vc=%b pkt=%h, want 0/00/0", out_valid, out_vc, out_packet);
      end
      n_chk++;
      if (credits !== {5'd31, 5'd31} || credit_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_credits: credits=%h err=%b, want 3ff/0", credits, credit_err);
      end
      n_chk++;
      if (in_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 00", in_ready);
      end
      rst = 1'b0;
      in_valid = '0;
   endtask

   task automatic test_round_robin;
      int n0, n1;
      logic [1:0] exp;
      logic [31:0] expp;
      n0 = 0;
      n1 = 0;
      do_reset();
      in_valid = 2'b11;
      for (int k = 0; k < 62; k++) begin
         in_packet = {mk(16'h1000 + 16'(k), 1'b1), mk(16'(k), 1'b1)};
         exp = k[0] ? 2'b10 : 2'b01;
         expp = k[0] ? mk(16'h1000 + 16'(k), 1'b1) : mk(16'(k), 1'b1);
         #1;
         if (in_ready == 2'b01) n0++;
         if (in_ready == 2'b10) n1++;
         n_chk++;
         if (in_ready !== exp) begin
            n_fail++;
            $display("FAIL rr_ready k=%0d: got %b want %b", k, in_ready, exp);
         end
         tick();
         n_chk++;
         if (out_valid !== 1'b1 || out_vc !== exp || out_packet !== expp) begin
            n_fail++;
            $display("FAIL rr_out k=%0d: v=%b vc=%b pkt=%h want 1/%b/%h", k, out_valid, out_vc, out_packet, exp, expp);
         end
      end
      n_chk++;
      if (n0 != 31 || n1 != 31) begin
         n_fail++;
         $display("FAIL rr_counts: vc0=%0d vc1=%0d want 31/31", n0, n1);
      end
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++;
         if (in_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL rr_drained_ready: got %b want 00", in_ready);
         end
         tick();
      end
      n_chk++;
      if (credits !== 10'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_drained: credits=%h v=%b want 0/0", credits, out_valid);
      end
      in_valid = '0;
   endtask

   task automatic test_wormhole;
      logic [1:0] exp;
      do_reset();
      in_valid = 2'b11;
      for (int k = 0; k < 5; k++) begin
         in_packet = {mk(16'h200 + 16'(k), 1'b1), mk(16'h100 + 16'(k), k == 3)};
         exp = (k < 4) ? 2'b01 : 2'b10;
         #1;
         n_chk++;
         if (in_ready !== exp) begin
            n_fail++;
            $display("FAIL worm_ready k=%0d: got %b want %b", k, in_ready, exp);
         end
         tick();
         n_chk++;
         if (out_valid !== 1'b1 || out_vc !== exp) begin
            n_fail++;
            $display("FAIL worm_out k=%0d: v=%b vc=%b want 1/%b", k, out_valid, out_vc, exp);
         end
      end
      in_valid = '0;
      tick();
   endtask

   task automatic test_lock_stall;
      do_reset();
      in_valid = 2'b11;
      in_packet = {mk(16'h300, 1'b1), mk(16'h400, 1'b0)};
      #1;
      n_chk++;
      if (in_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL stall_first: got %b want 01", in_ready);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         in_valid = 2'b10;
         #1;
         n_chk++;
         if (in_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_ready k=%0d: got %b want 00", k, in_ready);
         end
         tick();
         n_chk++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_idle k=%0d: out_valid=%b want 0", k, out_valid);
         end
      end
`ifdef NOC_VC_ARB_STATS_EN
      n_chk++;
      if (lock_stall_cnt !== 32'd3) begin
         n_fail++;
         $display("FAIL stall_cnt: got %0d want 3", lock_stall_cnt);
      end
`endif
      in_valid = 2'b11;
      in_packet = {mk(16'h300, 1'b1), mk(16'h401, 1'b1)};
      #1;
      n_chk++;
      if (in_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL stall_resume: got %b want 01", in_ready);
      end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_vc !== 2'b01 || out_packet !== mk(16'h401, 1'b1)) begin
         n_fail++;
         $display("FAIL stall_resume_out: v=%b vc=%b pkt=%h", out_valid, out_vc, out_packet);
      end
      in_valid = 2'b10;
      #1;
      n_chk++;
      if (in_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_release: got %b want 10", in_ready);
      end
      tick();
      in_valid = '0;
   endtask

   task automatic test_zero_credit;
      do_reset();
      in_valid = 2'b01;
      for (int k = 0; k < 31; k++) begin
         in_packet = {32'd0, mk(16'(k), 1'b1)};
         tick();
      end
      credit_return = 2'b01;
      #1;
      n_chk++;
      if (in_ready !== 2'b00 || credits[4:0] !== 5'd0) begin
         n_fail++;
         $display("FAIL zero_same_cycle: ready=%b cred0=%0d want 00/0", in_ready, credits[4:0]);
      end
      tick();
      credit_return = '0;
      #1;
      n_chk++;
      if (in_ready !== 2'b01 || credits[4:0] !== 5'd1) begin
         n_fail++;
         $display("FAIL zero_next_cycle: ready=%b cred0=%0d want 01/1", in_ready, credits[4:0]);
      end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || credits[4:0] !== 5'd0 || in_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL zero_after_send: v=%b cred0=%0d ready=%b", out_valid, credits[4:0], in_ready);
      end
      in_valid = '0;
   endtask

   task automatic test_credit_edges;
      do_reset();
      in_valid = 2'b10;
      for (int k = 0; k < 21; k++) begin
         in_packet = {mk(16'(k), 1'b1), 32'd0};
         tick();
      end
      n_chk++;
      if (credits[9:5] !== 5'd10) begin
         n_fail++;
         $display("FAIL cred_drain: cred1=%0d want 10", credits[9:5]);
      end
      credit_return = 2'b10;
      tick();
      credit_return = '0;
      in_valid = '0;
      n_chk++;
      if (credits[9:5] !== 5'd10 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL cred_same_cycle: cred1=%0d v=%b want 10/1", credits[9:5], out_valid);
      end
      n_chk++;
      if (credits[4:0] !== 5'd31 || credit_err !== 1'b0) begin
         n_fail++;
         $display("FAIL cred_pre_ovf: cred0=%0d err=%b want 31/0", credits[4:0], credit_err);
      end
      credit_return = 2'b01;
      tick();
      credit_return = '0;
      n_chk++;
      if (credits[4:0] !== 5'd31 || credit_err !== 1'b1) begin
         n_fail++;
         $display("FAIL cred_ovf: cred0=%0d err=%b want 31/1", credits[4:0], credit_err);
      end
      tick();
      tick();
      tick();
      n_chk++;
      if (credit_err !== 1'b1) begin
         n_fail++;
         $display("FAIL cred_err_sticky: got %b want 1", credit_err);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++;
      if (credit_err !== 1'b0) begin
         n_fail++;
         $display("FAIL cred_err_clear: got %b want 0", credit_err);
      end
   endtask

   task automatic test_reset_mid_packet;
      do_reset();
      in_valid = 2'b01;
      in_packet = {32'd0, mk(16'h500, 1'b0)};
      tick();
      n_chk++;
      if (credits[4:0] !== 5'd30 || out_vc !== 2'b01) begin
         n_fail++;
         $display("FAIL mid_first: cred0=%0d vc=%b want 30/01", credits[4:0], out_vc);
      end
      in_packet = {32'd0, mk(16'h501, 1'b0)};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = '0;
      n_chk++;
      if (out_valid !== 1'b0 || credits !== {5'd31, 5'd31}) begin
         n_fail++;
         $display("FAIL mid_reset: v=%b credits=%h want 0/3ff", out_valid, credits);
      end
      in_valid = 2'b10;
      in_packet = {mk(16'h600, 1'b1), 32'd0};
      #1;
      n_chk++;
      if (in_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL mid_fresh_ready: got %b want 10", in_ready);
      end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_vc !== 2'b10 || out_packet !== mk(16'h600, 1'b1)) begin
         n_fail++;
         $display("FAIL mid_fresh_out: v=%b vc=%b pkt=%h", out_valid, out_vc, out_packet);
      end
      in_valid = '0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = '0;
      in_packet = '0;
      credit_return = '0;
      test_reset();
      test_round_robin();
      test_wormhole();
      test_lock_stall();
      test_zero_credit();
      test_credit_edges();
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
